// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and default configuration for the pipeline stall/flush controller.
// Optional feature macro used by the top: PIPE_HAZARD_CTRL_PERF_EN.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned DEF_STAGES     = 6;
  localparam int unsigned DEF_NREQ       = 4;
  // Slice r lives at bits [r*STAGES +: STAGES]; the rightmost literal is req0 (mem).
  localparam logic [23:0] DEF_STALL_MASKS = {6'b000010, 6'b000011, 6'b000111, 6'b011111};
  localparam logic [5:0]  DEF_FLUSH_MASK  = 6'b000110;
  localparam logic [3:0]  DEF_DEFER_MASK  = 4'b0001;
  localparam int unsigned DEF_WDOG_LIMIT  = 1024;

  typedef enum logic [0:0] {
    PC_RUN  = 1'b0,
    PC_PEND = 1'b1
  } pc_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/pipe_prio_enc.sv
// Fixed-priority encoder: index 0 wins; reports winner index and a valid flag.
module pipe_prio_enc
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  // Scan from the lowest-priority end so the lowest active index is left last.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int r = int'(NREQ) - 1; r >= 0; r--) begin
      idx_o = req_i[r] ? IW'(r) : idx_o;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with flush deferral, stall watchdog and, when
// PIPE_HAZARD_CTRL_PERF_EN is defined, per-requester stall-cycle counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned              STAGES      = DEF_STAGES,
  parameter int unsigned              NREQ        = DEF_NREQ,
  parameter logic [NREQ*STAGES-1:0]   STALL_MASKS = DEF_STALL_MASKS,
  parameter logic [STAGES-1:0]        FLUSH_MASK  = DEF_FLUSH_MASK,
  parameter logic [NREQ-1:0]          DEFER_MASK  = DEF_DEFER_MASK,
  parameter int unsigned              WDOG_LIMIT  = DEF_WDOG_LIMIT,
  localparam int unsigned             SELW        = idx_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     stall_req_i,
  input  logic                flush_req_i,
  output logic [STAGES-1:0]   stall_o,
  output logic [STAGES-1:0]   flush_o,
  output logic                flush_pend_o,
  output logic                deadlock_o,
  input  logic [SELW-1:0]     perf_sel_i,
  output logic [31:0]         perf_cnt_o
);

  localparam int unsigned        WDW      = $clog2(WDOG_LIMIT + 1);
  localparam logic [WDW-1:0]     WDOG_LIM = WDW'(WDOG_LIMIT);

  logic [SELW-1:0]   win_idx_s;
  logic              win_valid_s;
  logic [STAGES-1:0] stall_s;
  logic [STAGES-1:0] flush_s;
  logic              pend_s;
  logic              defer_s;
  pc_state_e         state_q, state_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic              deadlock_q, deadlock_d;

  pipe_prio_enc #(.NREQ(NREQ)) u_prio (
    .req_i   (stall_req_i),
    .idx_o   (win_idx_s),
    .valid_o (win_valid_s)
  );

  assign defer_s = |(stall_req_i & DEFER_MASK);

  // Stall vector of the winning requester, forced off while in reset.
  always_comb begin
    stall_s = '0;
    if (rst) begin
      stall_s = '0;
    end else if (win_valid_s) begin
      stall_s = STALL_MASKS[win_idx_s*STAGES +: STAGES];
    end else begin
      stall_s = '0;
    end
  end

  // Flush FSM: a flush seen while a deferring stall is up waits in PEND; extra
  // requests in PEND fold into the single pending flush.
  always_comb begin
    state_d = state_q;
    flush_s = '0;
    pend_s  = 1'b0;
    if (rst) begin
      state_d = PC_RUN;
    end else begin
      case (state_q)
        PC_RUN: begin
          if (flush_req_i && defer_s) begin
            state_d = PC_PEND;
            pend_s  = 1'b1;
          end else if (flush_req_i) begin
            flush_s = FLUSH_MASK;
          end else begin
            state_d = PC_RUN;
          end
        end
        PC_PEND: begin
          if (defer_s) begin
            pend_s = 1'b1;
          end else begin
            flush_s = FLUSH_MASK;
            state_d = PC_RUN;
          end
        end
        default: state_d = PC_RUN;
      endcase
    end
  end

  // Watchdog counts consecutive stalled cycles and saturates at the limit.
  always_comb begin
    wdog_d = wdog_q;
    if (stall_s == '0) begin
      wdog_d = '0;
    end else if (wdog_q == WDOG_LIM) begin
      wdog_d = wdog_q;
    end else begin
      wdog_d = wdog_q + WDW'(1);
    end
    deadlock_d = deadlock_q | (wdog_d == WDOG_LIM);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PC_RUN;
      wdog_q     <= '0;
      deadlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign stall_o      = stall_s;
  assign flush_o      = flush_s;
  assign flush_pend_o = pend_s;
  assign deadlock_o   = deadlock_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_q [NREQ];
  logic [31:0] perf_cnt_q;

  // Per-requester win counters and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        perf_q[r] <= 32'd0;
      end
      perf_cnt_q <= 32'd0;
    end else begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (win_valid_s && (32'(win_idx_s) == r)) begin
          perf_q[r] <= perf_q[r] + 32'd1;
        end else begin
          perf_q[r] <= perf_q[r];
        end
      end
      perf_cnt_q <= (32'(perf_sel_i) < NREQ) ? perf_q[perf_sel_i] : 32'd0;
    end
  end

  assign perf_cnt_o = perf_cnt_q;
`else
  // Selector kept in the port list; it has no effect without counters.
  assign perf_cnt_o = 32'd0 & {32{^perf_sel_i}};
`endif

endmodule
